// File: rtl/seletor_tipo_rega.sv
// ============================================================================
// seletor_tipo_rega
//   Debounced push-button selector for the irrigation mode
//   (NENHUM -> ASPERSAO -> GOTEJAMENTO -> NENHUM), with lock and force-off.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seletor_tipo_rega #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    input  logic travar,
    input  logic desligar,
    output logic aspersao,
    output logic gotejamento,
    output logic mudou
);

    localparam int              CW      = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    localparam logic [1:0] NENHUM      = 2'b00;
    localparam logic [1:0] ASPERSAO    = 2'b01;
    localparam logic [1:0] GOTEJAMENTO = 2'b10;

    logic          sync1;
    logic          sync2;
    logic          estavel;
    logic [CW-1:0] counter;
    logic          evento;
    logic [1:0]    state;
    logic [1:0]    next_state;

    // Synchronizer, debounce window and press-edge detector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            estavel <= 1'b0;
            counter <= '0;
            evento  <= 1'b0;
        end else begin
            sync1  <= botao;
            sync2  <= sync1;
            evento <= 1'b0;
            if (sync2 == estavel) begin
                counter <= '0;
            end else if (counter == CNT_MAX) begin
                estavel <= sync2;
                counter <= '0;
                evento  <= sync2;
            end else begin
                counter <= counter + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= NENHUM;
            mudou <= 1'b0;
        end else begin
            state <= next_state;
            mudou <= (next_state != state);
        end
    end

    always_comb begin
        next_state = state;
        if (desligar) begin
            next_state = NENHUM;
        end else begin
            case (state)
                NENHUM:      if (evento && !travar) next_state = ASPERSAO;
                ASPERSAO:    if (evento && !travar) next_state = GOTEJAMENTO;
                GOTEJAMENTO: if (evento && !travar) next_state = NENHUM;
                default:     next_state = NENHUM;
            endcase
        end
    end

    always_comb begin
        aspersao    = (state == ASPERSAO);
        gotejamento = (state == GOTEJAMENTO);
    end

endmodule

`default_nettype wire

// File: doc/seletor_tipo_rega.md
Name: seletor_tipo_rega

Overview:
- Input-side counterpart of the irrigation-type display path. Turns a raw, bouncing push-button into a clean irrigation mode.
- Mode cycles NENHUM -> ASPERSAO -> GOTEJAMENTO -> NENHUM.
- Drives the one-hot-or-zero aspersao/gotejamento pair consumed by the seven-segment type driver and the valve control logic.
- Contains a synchronizer, a debounce counter, an edge detector and a 3-state FSM with lock and forced-off controls.

Parameters:
- DEBOUNCE_CICLOS, 4, consecutive clock cycles the synchronized button must differ from the debounced level before that level flips. Legal range 2..65535. Counter width is clog2(DEBOUNCE_CICLOS).

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  reset, asynchronous, active-low.
- botao  input  1  raw mechanical button, active-high, asynchronous to clock.
- travar  input  1  lock; while 1, button presses are discarded, not queued.
- desligar  input  1  synchronous force-to-NENHUM; priority over presses.
- aspersao  output  1  1 only in state ASPERSAO.
- gotejamento  output  1  1 only in state GOTEJAMENTO.
- mudou  output  1  one-cycle pulse on the edge where the mode changes.

Behaviour:
- Reset (reset_n=0, async): the following are cleared immediately, regardless of clock:
  - sync1, sync2, estavel, counter, evento, mudou = 0
  - state = NENHUM
  - aspersao = gotejamento = 0
- Reset asserted mid-debounce or mid-transition discards all progress.
- Synchronizer: sync1 <= botao; sync2 <= sync1. Only sync2 is used downstream.
- Debounce, on each edge:
  - If sync2 == estavel: counter <= 0.
  - Else if counter == DEBOUNCE_CICLOS-1: estavel <= sync2 and counter <= 0.
  - Else: counter <= counter+1.
  - A single cycle of agreement anywhere in the window restarts the count, so glitches shorter than DEBOUNCE_CICLOS cycles are rejected.
- Press event: evento is a register, set to 1 on the edge where estavel flips 0->1, otherwise 0. Release (1->0) creates no event.
- FSM, states encoded NENHUM=00, ASPERSAO=01, GOTEJAMENTO=10. Priority on each edge:
  - desligar=1: next = NENHUM.
  - evento=1 and travar=0: NENHUM->ASPERSAO, ASPERSAO->GOTEJAMENTO, GOTEJAMENTO->NENHUM.
  - Otherwise: hold.
  - Illegal encoding 11: next = NENHUM on the following edge; outputs 0 while in 11.
- Outputs decoded from the state register only, so they are glitch-free and never both 1.
- mudou is registered, and is 1 for exactly the cycle after an edge where next state differs from current state. desligar while already in NENHUM gives no pulse.
- Latency: botao first sampled 1 at edge E1 -> sync2=1 at E2 -> estavel and evento at E(2+DEBOUNCE_CICLOS) -> state, outputs and mudou at E(3+DEBOUNCE_CICLOS). With the default this is E7.
- Simultaneous events:
  - evento together with desligar -> NENHUM; the press is consumed.
  - evento together with travar=1 -> press lost.
  - travar does not block desligar.
- Button held through reset release: estavel rises after the debounce window and counts as one press.
- Holding the button produces exactly one event. A new event requires a debounced release then a debounced press.

Test Plan:
- Reset with botao=0, then a clean botao pulse held 10 cycles, DEBOUNCE_CICLOS=4 -> aspersao=1 at the 7th edge after the first sample, mudou=1 for exactly 1 cycle, gotejamento=0.
- Three clean presses separated by 10-cycle releases -> outputs (1,0), (0,1), (0,0) in sequence, with 3 mudou pulses.
- botao toggling with 1-, 2- and 3-cycle highs separated by 1-cycle lows -> no state change, mudou never set.
- Press while travar=1, then release travar -> state stays NENHUM and no delayed transition. Same press with travar=0 -> ASPERSAO.
- In GOTEJAMENTO, assert desligar on the edge where evento=1 -> NENHUM with one mudou pulse. desligar again in NENHUM -> no pulse.
- Pull reset_n low asynchronously mid-debounce while in ASPERSAO -> outputs 0 immediately. Release with botao held -> ASPERSAO reached DEBOUNCE_CICLOS+3 edges later.
